// File: rtl/lbm_pkg.sv
// Shared definitions for the D2Q9 LBM pipeline stages.
package lbm_pkg;

    // Number of lattice directions in D2Q9.
    localparam int Q_DIRS = 9;

    // Width of the intermediate value handed to the saturation helper.
    localparam int SAT_W = 64;

    // D2Q9 lattice velocity components, indexed by direction 0..8.
    localparam logic signed [1:0] D2Q9_EX [Q_DIRS] = '{
        2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb00, 2'sb01, 2'sb11, 2'sb11, 2'sb01
    };
    localparam logic signed [1:0] D2Q9_EY [Q_DIRS] = '{
        2'sb00, 2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb01, 2'sb01, 2'sb11, 2'sb11
    };

    // Macro-moment sweep controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ACC,
        ST_DIV_START,
        ST_DIV_WAIT,
        ST_WRITE,
        ST_DONE
    } mm_state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    // The result stays SAT_W wide; callers truncate it to w bits.
    function automatic logic signed [SAT_W-1:0] sat_s(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (x > max_v) begin
            return max_v;
        end
        if (x < min_v) begin
            return min_v;
        end
        return x;
    endfunction

endpackage

// File: rtl/lbm_fxp_div.sv
// Signed fixed-point divider: quot = sat((num << FRAC_BITS) / den), truncated
// toward zero. Restoring division on magnitudes with a sign fix-up, two
// quotient bits per cycle over a 2*DATA_WIDTH dividend, so the result is
// valid exactly DATA_WIDTH+1 cycles after the start cycle. A non-positive
// denominator yields a zero quotient and raises div_zero.
import lbm_pkg::*;

module lbm_fxp_div #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] num,
    input  logic signed [DATA_WIDTH-1:0] den,
    output logic                         valid,
    output logic signed [DATA_WIDTH-1:0] quot,
    output logic                         div_zero
);

    localparam int DW2   = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic                         busy_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [DATA_WIDTH-1:0]        rem_reg;
    logic [DATA_WIDTH-1:0]        rem_next;
    logic [DW2-1:0]               dvd_reg;
    logic [DW2-1:0]               dvd_next;
    logic [DATA_WIDTH-1:0]        den_mag_reg;
    logic                         neg_reg;
    logic                         dz_reg;
    logic signed [DATA_WIDTH-1:0] quot_reg;
    logic                         valid_reg;

    logic [DATA_WIDTH-1:0]        num_mag;
    logic [DATA_WIDTH-1:0]        den_mag;
    logic                         den_le0;
    logic [DATA_WIDTH:0]          trial;
    logic signed [SAT_W-1:0]      q_wide;
    logic signed [DATA_WIDTH-1:0] q_sat;

    assign num_mag = num[DATA_WIDTH-1] ? $unsigned(-num) : $unsigned(num);
    assign den_mag = den[DATA_WIDTH-1] ? $unsigned(-den) : $unsigned(den);
    assign den_le0 = den[DATA_WIDTH-1] | (den == '0);

    // Two restoring steps per cycle; quotient bits shift into the dividend LSBs.
    always_comb begin
        rem_next = rem_reg;
        dvd_next = dvd_reg;
        trial    = '0;
        for (int s = 0; s < 2; s++) begin
            trial    = {rem_next, dvd_next[DW2-1]};
            dvd_next = {dvd_next[DW2-2:0], 1'b0};
            if (trial >= {1'b0, den_mag_reg}) begin
                trial       = trial - {1'b0, den_mag_reg};
                dvd_next[0] = 1'b1;
            end
            rem_next = trial[DATA_WIDTH-1:0];
        end
        q_wide = SAT_W'($signed(dvd_next));
        if (neg_reg) begin
            q_wide = -q_wide;
        end
        q_sat = DATA_WIDTH'(sat_s(q_wide, DATA_WIDTH));
    end

    // Load operands on start, iterate while busy, publish on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg    <= 1'b0;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            den_mag_reg <= '0;
            neg_reg     <= 1'b0;
            dz_reg      <= 1'b0;
            quot_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (start) begin
                busy_reg    <= 1'b1;
                cnt_reg     <= '0;
                rem_reg     <= '0;
                dvd_reg     <= {{DATA_WIDTH{1'b0}}, num_mag} << FRAC_BITS;
                den_mag_reg <= den_mag;
                neg_reg     <= num[DATA_WIDTH-1] ^ den[DATA_WIDTH-1];
                dz_reg      <= den_le0;
            end else if (busy_reg) begin
                rem_reg <= rem_next;
                dvd_reg <= dvd_next;
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b1;
                    quot_reg  <= dz_reg ? '0 : q_sat;
                end
            end
        end
    end

    assign valid    = valid_reg;
    assign quot     = quot_reg;
    assign div_zero = dz_reg;

endmodule

// File: rtl/lbm_macro_moments.sv
// D2Q9 macroscopic-moment stage: per node, reads nine populations, forms
// rho/jx/jy, divides momentum by density and writes rho, ux, uy.
import lbm_pkg::*;

module lbm_macro_moments #(
    parameter int GRID_DIM   = 256,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          fin_rd_en,
    output logic [$clog2(GRID_DIM)-1:0]   fin_node,
    output logic [3:0]                    fin_dir,
    input  logic signed [DATA_WIDTH-1:0]  fin_rdata,
    output logic [$clog2(GRID_DIM)-1:0]   wr_addr,
    output logic                          WE_p_mem,
    output logic                          WE_ux_mem,
    output logic                          WE_uy_mem,
    output logic signed [DATA_WIDTH-1:0]  p_wdata,
    output logic signed [DATA_WIDTH-1:0]  ux_wdata,
    output logic signed [DATA_WIDTH-1:0]  uy_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          div_zero
);

    localparam int NODE_W = $clog2(GRID_DIM);
    localparam int ACC_W  = DATA_WIDTH + 4;

    mm_state_t                    state_reg;
    mm_state_t                    state_next;
    logic [NODE_W-1:0]            node_reg;
    logic [3:0]                   dir_reg;
    logic                         rd_pending_reg;
    logic [3:0]                   rd_dir_reg;
    logic signed [ACC_W-1:0]      rho_acc_reg;
    logic signed [ACC_W-1:0]      jx_acc_reg;
    logic signed [ACC_W-1:0]      jy_acc_reg;
    logic signed [ACC_W-1:0]      rho_acc_next;
    logic signed [ACC_W-1:0]      jx_acc_next;
    logic signed [ACC_W-1:0]      jy_acc_next;
    logic signed [DATA_WIDTH-1:0] rho_sat_reg;
    logic signed [DATA_WIDTH-1:0] jx_sat_reg;
    logic signed [DATA_WIDTH-1:0] jy_sat_reg;
    logic                         div_zero_reg;

    logic signed [ACC_W-1:0]      f_ext;
    logic signed [1:0]            ex;
    logic signed [1:0]            ey;

    logic                         div_start;
    logic signed [DATA_WIDTH-1:0] div_num  [2];
    logic signed [DATA_WIDTH-1:0] div_quot [2];
    logic [1:0]                   div_valid;
    logic [1:0]                   div_dz;

    // Next-state and control outputs, all decoded from the state register.
    always_comb begin
        state_next = state_reg;
        fin_rd_en  = 1'b0;
        WE_p_mem   = 1'b0;
        WE_ux_mem  = 1'b0;
        WE_uy_mem  = 1'b0;
        div_start  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                fin_rd_en = 1'b1;
                if (dir_reg == 4'(Q_DIRS - 1)) begin
                    state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                state_next = ST_DIV_START;
            end
            ST_DIV_START: begin
                div_start  = 1'b1;
                state_next = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                if (&div_valid) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                WE_p_mem  = 1'b1;
                WE_ux_mem = 1'b1;
                WE_uy_mem = 1'b1;
                if (node_reg == NODE_W'(GRID_DIM - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_READ;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Fold in the population returned for the previous cycle's read.
    always_comb begin
        f_ext        = ACC_W'(fin_rdata);
        ex           = D2Q9_EX[rd_dir_reg];
        ey           = D2Q9_EY[rd_dir_reg];
        rho_acc_next = rho_acc_reg;
        jx_acc_next  = jx_acc_reg;
        jy_acc_next  = jy_acc_reg;
        if (rd_pending_reg) begin
            rho_acc_next = rho_acc_reg + f_ext;
            case (ex)
                2'sb01:  jx_acc_next = jx_acc_reg + f_ext;
                2'sb11:  jx_acc_next = jx_acc_reg - f_ext;
                default: jx_acc_next = jx_acc_reg;
            endcase
            case (ey)
                2'sb01:  jy_acc_next = jy_acc_reg + f_ext;
                2'sb11:  jy_acc_next = jy_acc_reg - f_ext;
                default: jy_acc_next = jy_acc_reg;
            endcase
        end
    end

    // State register plus the sweep datapath (addresses, accumulators, flag).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            node_reg       <= '0;
            dir_reg        <= '0;
            rd_pending_reg <= 1'b0;
            rd_dir_reg     <= '0;
            rho_acc_reg    <= '0;
            jx_acc_reg     <= '0;
            jy_acc_reg     <= '0;
            rho_sat_reg    <= '0;
            jx_sat_reg     <= '0;
            jy_sat_reg     <= '0;
            div_zero_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_pending_reg <= (state_reg == ST_READ);
            rd_dir_reg     <= dir_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        node_reg     <= '0;
                        dir_reg      <= '0;
                        div_zero_reg <= 1'b0;
                        rho_acc_reg  <= '0;
                        jx_acc_reg   <= '0;
                        jy_acc_reg   <= '0;
                    end
                end
                ST_READ: begin
                    rho_acc_reg <= rho_acc_next;
                    jx_acc_reg  <= jx_acc_next;
                    jy_acc_reg  <= jy_acc_next;
                    if (dir_reg == 4'(Q_DIRS - 1)) begin
                        dir_reg <= '0;
                    end else begin
                        dir_reg <= dir_reg + 4'd1;
                    end
                end
                ST_ACC: begin
                    rho_acc_reg <= rho_acc_next;
                    jx_acc_reg  <= jx_acc_next;
                    jy_acc_reg  <= jy_acc_next;
                    rho_sat_reg <= DATA_WIDTH'(sat_s(SAT_W'(rho_acc_next), DATA_WIDTH));
                    jx_sat_reg  <= DATA_WIDTH'(sat_s(SAT_W'(jx_acc_next), DATA_WIDTH));
                    jy_sat_reg  <= DATA_WIDTH'(sat_s(SAT_W'(jy_acc_next), DATA_WIDTH));
                end
                ST_DIV_WAIT: begin
                    if (&div_valid) begin
                        div_zero_reg <= div_zero_reg | (|div_dz);
                    end
                end
                ST_WRITE: begin
                    if (node_reg != NODE_W'(GRID_DIM - 1)) begin
                        node_reg    <= node_reg + 1'b1;
                        dir_reg     <= '0;
                        rho_acc_reg <= '0;
                        jx_acc_reg  <= '0;
                        jy_acc_reg  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_num[0] = jx_sat_reg;
    assign div_num[1] = jy_sat_reg;

    // ux and uy dividers run in lockstep on the same density.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            lbm_fxp_div #(
                .DATA_WIDTH (DATA_WIDTH),
                .FRAC_BITS  (FRAC_BITS)
            ) u_div (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (div_start),
                .num      (div_num[gi]),
                .den      (rho_sat_reg),
                .valid    (div_valid[gi]),
                .quot     (div_quot[gi]),
                .div_zero (div_dz[gi])
            );
        end
    endgenerate

    assign fin_node = node_reg;
    assign fin_dir  = dir_reg;
    assign wr_addr  = node_reg;
    assign p_wdata  = rho_sat_reg;
    assign ux_wdata = div_quot[0];
    assign uy_wdata = div_quot[1];
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_lbm_macro_moments.sv
// Scoreboard bench for lbm_macro_moments: directed node vectors, a mid-sweep
// reset, two full sweeps with timing, sticky div_zero and start-ignore checks.
`timescale 1ns/1ps

module tb_lbm_macro_moments;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fin_rd_en;
    logic [7:0]  fin_node;
    logic [3:0]  fin_dir;
    logic [31:0] fin_rdata = '0;
    logic [7:0]  wr_addr;
    logic        WE_p_mem, WE_ux_mem, WE_uy_mem;
    logic [31:0] p_wdata, ux_wdata, uy_wdata;
    logic        busy, done, div_zero;

    lbm_macro_moments #(
        .GRID_DIM   (256),
        .DATA_WIDTH (32),
        .FRAC_BITS  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fin_rd_en (fin_rd_en),
        .fin_node  (fin_node),
        .fin_dir   (fin_dir),
        .fin_rdata (fin_rdata),
        .wr_addr   (wr_addr),
        .WE_p_mem  (WE_p_mem),
        .WE_ux_mem (WE_ux_mem),
        .WE_uy_mem (WE_uy_mem),
        .p_wdata   (p_wdata),
        .ux_wdata  (ux_wdata),
        .uy_wdata  (uy_wdata),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] p;
        logic [31:0] ux;
        logic [31:0] uy;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [256][9];
    int          cyc = 0;
    int          t0 = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // f_in memory model: one-cycle read latency.
    always @(posedge clk) if (fin_rd_en) fin_rdata <= mem[fin_node][fin_dir];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write is popped against the scoreboard.
    always @(negedge clk) begin
        if (WE_p_mem || WE_ux_mem || WE_uy_mem) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=node %0d required=no write", wr_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("write node %0d cycle %0d p=%h ux=%h uy=%h dz=%0d",
                         wr_addr, cyc - t0, p_wdata, ux_wdata, uy_wdata, div_zero);
                chk("we_all", {29'd0, WE_p_mem, WE_ux_mem, WE_uy_mem}, 32'd7);
                chk("wr_addr", {24'd0, wr_addr}, e.addr);
                chk("p_wdata", p_wdata, e.p);
                chk("ux_wdata", ux_wdata, e.ux);
                chk("uy_wdata", uy_wdata, e.uy);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                chk("write_cycle", cyc - t0, e.cyc);
                chk("rd_overlap", {31'd0, fin_rd_en}, 32'd0);
            end
        end
    end

    // Sweep A contents: directed nodes 0..8, node index fill elsewhere.
    task automatic load_mem_a();
        for (int k = 0; k < 256; k++)
            for (int d = 0; d < 9; d++)
                mem[k][d] = (k >= 9) ? k : 0;
        mem[1][0] = 32'h0001_0000;
        mem[2][0] = 32'h0001_0000; mem[2][1] = 32'h0001_0000;
        mem[3][0] = 32'h0001_0000; mem[3][7] = 32'h0001_0000;
        mem[4][0] = 32'h8001_0001; mem[4][1] = 32'h7FFF_0000;
        mem[5][0] = 32'h8001_0001; mem[5][3] = 32'h7FFF_0000;
        for (int d = 0; d < 9; d++) mem[6][d] = 32'h7FFF_FFFF;
        mem[7][0] = 32'h0001_0000; mem[7][2] = 32'h0001_0000; mem[7][6] = 32'h0001_0000;
        mem[8][0] = 32'hFFFF_0000; mem[8][1] = 32'h0000_8000;
    endtask

    // Hand-computed results for sweep A; node 0 has zero density so div_zero stays set.
    task automatic push_a(input int n_nodes);
        for (int k = 0; k < n_nodes; k++) begin
            exp_t e;
            e.addr = k; e.dz = 1'b1; e.cyc = 45 * (k + 1);
            e.ux = 32'h0; e.uy = 32'h0;
            case (k)
                0: e.p = 32'h0000_0000;
                1: e.p = 32'h0001_0000;
                2: begin e.p = 32'h0002_0000; e.ux = 32'h0000_8000; end
                3: begin e.p = 32'h0002_0000; e.ux = 32'hFFFF_8000; e.uy = 32'hFFFF_8000; end
                4: begin e.p = 32'h0000_0001; e.ux = 32'h7FFF_FFFF; end
                5: begin e.p = 32'h0000_0001; e.ux = 32'h8000_0000; end
                6: e.p = 32'h7FFF_FFFF;
                7: begin e.p = 32'h0003_0000; e.ux = 32'hFFFF_AAAB; e.uy = 32'h0000_AAAA; end
                8: e.p = 32'hFFFF_8000;
                default: e.p = 9 * k;
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctrl"}, {25'd0, fin_rd_en, WE_p_mem, WE_ux_mem, WE_uy_mem, busy, done, div_zero}, 32'd0);
        chk({tag, "_addr"}, {12'd0, fin_node, fin_dir, wr_addr}, 32'd0);
        chk({tag, "_p"}, p_wdata, 32'd0);
        chk({tag, "_ux"}, ux_wdata, 32'd0);
        chk({tag, "_uy"}, uy_wdata, 32'd0);
    endtask

    task automatic wait_done(input string name);
        int seen;
        seen = -1;
        for (int i = 0; i < 13000 && seen < 0; i++) begin
            if (done) seen = cyc - t0;
            else begin @(posedge clk); #1; end
        end
        chk(name, seen, 11521);
        if (seen >= 0) begin
            @(posedge clk); #1;
            chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
            chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        end
        chk({name, "_all_written"}, exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        load_mem_a();
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Sweep interrupted by reset during node 3: only nodes 0..2 written.
        push_a(3);
        do_start();
        wait_rel(160);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("midreset_pending", exp_q.size(), 0);
        chk("midreset_idle", {31'd0, busy}, 32'd0);

        // Sweep A: full timing, second start ignored, sticky div_zero.
        push_a(256);
        do_start();
        chk("a_busy_c1", {31'd0, busy}, 32'd1);
        chk("a_rd_c1", {27'd0, fin_rd_en, fin_dir}, 32'h10);
        wait_rel(100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("a_busy_c101", {31'd0, busy}, 32'd1);
        chk("a_node_c101", {24'd0, fin_node}, 32'd2);
        wait_done("a_done_cycle");
        chk("a_div_zero_sticky", {31'd0, div_zero}, 32'd1);

        // Sweep B: positive densities everywhere, div_zero cleared by start.
        for (int k = 0; k < 256; k++) begin
            exp_t e;
            for (int d = 0; d < 9; d++) mem[k][d] = 32'd0;
            mem[k][0] = (k + 1) << 16;
            e.addr = k; e.p = (k + 1) << 16; e.ux = 32'd0; e.uy = 32'd0;
            e.dz = 1'b0; e.cyc = 45 * (k + 1);
            exp_q.push_back(e);
        end
        do_start();
        chk("b_div_zero_cleared", {31'd0, div_zero}, 32'd0);
        wait_done("b_done_cycle");
        chk("b_div_zero_end", {31'd0, div_zero}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lbm_macro_moments.md
# lbm_macro_moments

Macroscopic-moment stage of the D2Q9 LBM pipeline. Sweeps all GRID_DIM nodes, reads the nine f_in populations of each node from the f_in memory, accumulates density and momentum, divides momentum by density, and writes rho, ux, uy into the p/ux/uy memories. Sits downstream of the f_in memory and upstream of the equilibrium (f_eq) stage. The top-level controller launches it with `start` and waits for `done`.

## Interface
- GRID_DIM, 256, nodes per sweep.
- DATA_WIDTH, 32, signed fixed-point word width.
- FRAC_BITS, 16, fractional bits (Q16.16 at defaults).

- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle sweep request; ignored unless idle.
- fin_rd_en  out  1  f_in memory read strobe.
- fin_node  out  $clog2(GRID_DIM)  node address of the read.
- fin_dir  out  4  direction 0..8 of the read.
- fin_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after fin_rd_en.
- wr_addr  out  $clog2(GRID_DIM)  node address for p/ux/uy writes.
- WE_p_mem, WE_ux_mem, WE_uy_mem  out  1 each  write enables.
- p_wdata, ux_wdata, uy_wdata  out  DATA_WIDTH each  rho, ux, uy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of the sweep.
- div_zero  out  1  sticky flag, set when any node has rho <= 0; cleared by start or reset.

## Operation
- Direction vectors (ex,ey): 0 (0,0), 1 (1,0), 2 (0,1), 3 (-1,0), 4 (0,-1), 5 (1,1), 6 (-1,1), 7 (-1,-1), 8 (1,-1).
- Accumulators are DATA_WIDTH+4 bits, signed:
  - rho = sum f
  - jx = sum ex*f
  - jy = sum ey*f
  - Cleared at the start of each node.
- rho, jx, jy are saturated to DATA_WIDTH before use. p_wdata = saturated rho.
- ux = (jx << FRAC_BITS) / rho and uy likewise.
  - Truncate toward zero, then saturate to DATA_WIDTH.
  - If rho <= 0: ux = uy = 0 and div_zero is set.
- FSM states:
  - IDLE: on start → READ; node=0, dir=0, div_zero cleared.
  - READ: 9 cycles. Issue fin_rd_en with dir 0..8. Each cycle accumulates the data returned for dir-1 (none in the first cycle).
  - ACC: 1 cycle. Accumulate dir-8 data; saturate.
  - DIV_START: 1 cycle. Pulse start to both dividers (ux and uy run in parallel).
  - DIV_WAIT: hold until both quotients are valid.
  - WRITE: 1 cycle. All three WE high at wr_addr=node. Then:
    - node == GRID_DIM-1 → DONE.
    - Otherwise node+1 → READ.
  - DONE: done=1 for 1 cycle → IDLE.
- start during any non-IDLE state is ignored.
- Reset mid-sweep: immediate return to IDLE, dividers aborted, no further writes.
- Reset values: all outputs 0, accumulators 0, state IDLE.

## Timing
- start is sampled in cycle 0; the first READ cycle is cycle 1.
- Divider: quotient valid exactly DATA_WIDTH+1 cycles after its start cycle.
- Node period = DATA_WIDTH+13 cycles (45 at defaults): 9 READ + 1 ACC + 1 DIV_START + DATA_WIDTH+1 wait + 1 WRITE.
- Write of node k occurs in cycle (DATA_WIDTH+13)*(k+1).
- done occurs one cycle after the last write: cycle 11521 at defaults.
- fin_rd_en never overlaps a WRITE cycle.

## Structure
- `lbm_pkg` holds:
  - Q_DIRS=9.
  - D2Q9 EX/EY constant arrays.
  - FSM state enum.
  - Saturation function, shared with the f_eq stage.
- Sub-module `lbm_fxp_div`:
  - Signed sequential restoring divider with start/valid handshake.
  - Magnitude division with sign fix-up.
  - Internal width 2*DATA_WIDTH, fixed latency DATA_WIDTH+1.
  - Reports divide-by-zero (rho <= 0).
  - Instantiated twice.

## Test plan
- Reset: assert Reset low during node 3 of a sweep → all outputs 0 within the same cycle, no WE afterwards. After release, start runs a full sweep normally.
- Rest node: f0=0x00010000, others 0 → p=0x00010000, ux=uy=0x00000000.
- x-flow: f0=f1=0x00010000, others 0 → p=0x00020000, ux=0x00008000, uy=0.
- Negative diagonal: f0=f7=0x00010000 → ux=uy=0xFFFF8000.
- Zero density: all f=0 → ux=uy=0, div_zero=1 and stays 1 to the end of the sweep. Cleared by the next start.
- Full sweep timing: start at cycle 0 with fin=node index → writes at cycles 45, 90, …, 11520; done in cycle 11521. A second start at cycle 100 is ignored, and busy stays high until done.
